integral_image_gen: RTL and testbench

Streaming producer of the integral image and squared integral image that the window statistics and feature evaluation logic consume. It accepts one 8-bit grayscale pixel per handshake in raster order. For each pixel it emits the inclusive 32-bit integral value ii[r][c] = Σ p[i][j] and the squared integral value ii_sq[r][c] = Σ p[i][j]², both summed over i ≤ r, j ≤ c. It sits between the pixel source (camera/downscaler) and the scan-window buffers that assemble `WINDOW_SIZE+1`-square corner windows.

---
 rtl/integral_image_gen.sv | 95 +++++++++
 tb/tb_integral_image_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/integral_image_gen.sv
// Streams integral and squared-integral values for a raster-order 8-bit image.
// One-cycle latency through a single output register; pixel_ready drops only while a result is held unconsumed.
module integral_image_gen #(
  parameter int IMG_W = 40,
  parameter int IMG_H = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               pixel_in,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic [31:0]              ii_out,
  output logic [31:0]              ii_sq_out,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   rs;
  logic [31:0]   rs_sq;
  logic [31:0]   prev_ii [IMG_W];
  logic [31:0]   prev_sq [IMG_W];

  logic        in_xfer;
  logic        col_end;
  logic        row_end;
  logic [15:0] sq;
  logic [31:0] rs_new;
  logic [31:0] rs_sq_new;
  logic [31:0] ii_new;
  logic [31:0] ii_sq_new;

  assign pixel_ready = !out_valid || out_ready;
  assign in_xfer     = pixel_valid && pixel_ready;
  assign col_end     = (col == COL_MAX);
  assign row_end     = (row == ROW_MAX);

  // Row buffers are read asynchronously, so the previous row's value is available in the same cycle.
  always_comb begin
    sq        = 16'(pixel_in) * 16'(pixel_in);
    rs_new    = ((col == '0) ? 32'd0 : rs) + 32'(pixel_in);
    rs_sq_new = ((col == '0) ? 32'd0 : rs_sq) + 32'(sq);
    ii_new    = rs_new + ((row == '0) ? 32'd0 : prev_ii[col]);
    ii_sq_new = rs_sq_new + ((row == '0) ? 32'd0 : prev_sq[col]);
  end

  // Row buffers are deliberately left out of reset; row 0 never reads them.
  always_ff @(posedge clock) begin
    if (in_xfer) begin
      prev_ii[col] <= ii_new;
      prev_sq[col] <= ii_sq_new;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      rs        <= '0;
      rs_sq     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ii_out    <= '0;
      ii_sq_out <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (in_xfer) begin
      rs        <= rs_new;
      rs_sq     <= rs_sq_new;
      ii_out    <= ii_new;
      ii_sq_out <= ii_sq_new;
      out_row   <= row;
      out_col   <= col;
      out_last  <= col_end && row_end;
      out_valid <= 1'b1;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed-vector bench for integral_image_gen on a 4x3 image with a summation model and scoreboard.
module tb_integral_image_gen;
  localparam int W = 4;
  localparam int H = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [31:0] ii_out;
  logic [31:0] ii_sq_out;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  integral_image_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .ii_out(ii_out), .ii_sq_out(ii_sq_out),
    .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned ii;
    int unsigned sq;
    int          r;
    int          c;
    bit          last;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  img [H][W];
  int unsigned got_ii [H][W];
  int unsigned got_sq [H][W];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          last_cnt = 0;
  bit          held_vld = 0;
  logic [31:0] h_ii, h_sq;
  logic [1:0]  h_row, h_col;
  logic        h_last;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plain double sum over the rectangle (0,0)..(r,c) of the current image.
  function automatic int unsigned model(input int r, input int c, input bit squared);
    int unsigned s = 0;
    for (int i = 0; i <= r; i++)
      for (int j = 0; j <= c; j++)
        s += squared ? int'(img[i][j]) * int'(img[i][j]) : int'(img[i][j]);
    return s;
  endfunction

  function automatic void fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          1:       img[r][c] = 8'd1;
          2:       img[r][c] = 8'd2;
          3:       img[r][c] = 8'd255;
          default: img[r][c] = 8'(4 * r + c);
        endcase
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      held_vld = 0;
    end else begin
      chk("ready_rule", pixel_ready, !out_valid || out_ready);
      if (held_vld) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_ii", ii_out, h_ii);
        chk("hold_sq", ii_sq_out, h_sq);
        chk("hold_pos", {out_row, out_col, out_last}, {h_row, h_col, h_last});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("ii", ii_out, e.ii);
          chk("ii_sq", ii_sq_out, e.sq);
          chk("row", 32'(out_row), e.r);
          chk("col", 32'(out_col), e.c);
          chk("last", 32'(out_last), 32'(e.last));
          got_ii[e.r][e.c] = ii_out;
          got_sq[e.r][e.c] = ii_sq_out;
          if (e.r == 0 && e.c == 0) first_cyc = cyc;
          if (e.last) last_cyc = cyc;
        end
        if (out_last) last_cnt++;
      end
      held_vld = out_valid && !out_ready;
      h_ii = ii_out; h_sq = ii_sq_out; h_row = out_row; h_col = out_col; h_last = out_last;
    end
  end

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.r = k / W; e.c = k % W;
      e.ii = model(e.r, e.c, 0);
      e.sq = model(e.r, e.c, 1);
      e.last = (e.r == H - 1) && (e.c == W - 1);
      expq.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      bit acc = 0;
      int guard = 0;
      pixel_in = img[k / W][k % W];
      pixel_valid = 1'b1;
      while (!acc && guard < 200) begin
        @(negedge clock);
        acc = pixel_ready;
        @(posedge clock);
        #1;
        guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    pixel_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clock);
    #1;
    chk("drain", expq.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ii", ii_out, 0);
    chk("rst_sq", ii_sq_out, 0);
    chk("rst_pos", {out_row, out_col}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", pixel_ready, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int lc;
    reset = 1'b1;
    pixel_in = '0;
    pixel_valid = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // All ones, continuous flow
    fill(1);
    lc = last_cnt;
    send(W * H);
    drain();
    chk("ones_final", got_ii[2][3], 12);
    chk("ones_final_sq", got_sq[2][3], 12);
    chk("ones_span", last_cyc - first_cyc, 11);
    chk("ones_last_cnt", last_cnt - lc, 1);

    // All 255
    fill(3);
    send(W * H);
    drain();
    chk("f255_final", got_ii[2][3], 3060);
    chk("f255_final_sq", got_sq[2][3], 780300);
    chk("f255_r0c3", got_ii[0][3], 1020);
    chk("f255_r0c3_sq", got_sq[0][3], 260100);

    // Ramp 4r+c
    fill(0);
    send(W * H);
    drain();
    chk("ramp_12", got_ii[1][2], 18);
    chk("ramp_12_sq", got_sq[1][2], 82);
    chk("ramp_23", got_ii[2][3], 66);
    chk("ramp_23_sq", got_sq[2][3], 506);

    // Backpressure for 5 cycles after the first output
    fill(1);
    fork
      send(W * H);
      begin
        int g = 0;
        while (!out_valid && g < 100) begin @(posedge clock); #1; g++; end
        chk("bp_first_out", out_valid, 1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          chk("bp_ready_low", pixel_ready, 0);
          chk("bp_valid_high", out_valid, 1);
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_final", got_ii[2][3], 12);

    // Reset mid-frame after 6 pixels, then a fresh frame
    send(6);
    drain();
    do_reset();
    send(W * H);
    drain();
    chk("mid_rst_first", got_ii[0][0], 1);
    chk("mid_rst_r0c3", got_ii[0][3], 4);

    // Back-to-back ones then twos
    lc = last_cnt;
    send(W * H);
    fill(2);
    send(W * H);
    drain();
    chk("b2b_first", got_ii[0][0], 2);
    chk("b2b_first_sq", got_sq[0][0], 4);
    chk("b2b_final", got_ii[2][3], 24);
    chk("b2b_final_sq", got_sq[2][3], 48);
    chk("b2b_last_cnt", last_cnt - lc, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
